control_unit: RTL and testbench

//  Hardwired sequencer upstream of the `system` datapath (ARF, RF, IR, Memory, muxes).
//  It drives every datapath control input.

---
 rtl/cu_pkg.sv | 65 ++++++
 rtl/cu_decoder.sv | 101 ++++++++++
 rtl/control_unit.sv | 93 +++++++++
 tb/tb_control_unit.sv | 271 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/cu_pkg.sv
// Shared types and constants for the hardwired control unit: state encoding, opcodes and the
// packed control word driven onto the datapath.
package cu_pkg;

  typedef enum logic [2:0] {
    INIT    = 3'd0,
    IDLE    = 3'd1,
    FETCH_L = 3'd2,
    FETCH_H = 3'd3,
    EXEC1   = 3'd4,
    EXEC2   = 3'd5,
    HALT    = 3'd6
  } state_t;

  localparam logic [3:0] OP_LDI = 4'h0;
  localparam logic [3:0] OP_LD  = 4'h1;
  localparam logic [3:0] OP_ST  = 4'h2;
  localparam logic [3:0] OP_MOV = 4'h3;
  localparam logic [3:0] OP_INC = 4'h4;
  localparam logic [3:0] OP_DEC = 4'h5;
  localparam logic [3:0] OP_CLR = 4'h6;
  localparam logic [3:0] OP_BRA = 4'h7;
  localparam logic [3:0] OP_HLT = 4'hF;

  localparam logic [3:0] ALU_PASS_A_DEFAULT = 4'h0;

  typedef struct packed {
    logic [1:0] outasel;
    logic [1:0] outbsel;
    logic [1:0] funsel_IR;
    logic [1:0] funsel_arf;
    logic [1:0] funsel_rf;
    logic [3:0] funsel_alu;
    logic [3:0] regsel_rf;
    logic [3:0] regsel_arf;
    logic [3:0] rf_tsel;
    logic       wrMEM;
    logic       csMEM;
    logic       IR_enable;
    logic       IR_lh;
    logic       MUXSelC;
    logic [1:0] MUXSelA;
    logic [1:0] MUXSelB;
    logic [2:0] rf_o1sel;
    logic [2:0] rf_o2sel;
  } ctrl_t;

  // Every register enable off, memory deselected.
  localparam ctrl_t CTRL_IDLE = '{
    outasel: 2'b00, outbsel: 2'b00, funsel_IR: 2'b00, funsel_arf: 2'b00, funsel_rf: 2'b00,
    funsel_alu: 4'h0, regsel_rf: 4'h0, regsel_arf: 4'h0, rf_tsel: 4'h0,
    wrMEM: 1'b0, csMEM: 1'b1, IR_enable: 1'b0, IR_lh: 1'b0, MUXSelC: 1'b0,
    MUXSelA: 2'b00, MUXSelB: 2'b00, rf_o1sel: 3'b000, rf_o2sel: 3'b000
  };

  // Field n addresses R(n+1): write enable is bit (3-n), read select is 3'b100 + n.
  function automatic logic [3:0] rf_onehot(input logic [1:0] n);
    return 4'b1000 >> n;
  endfunction

  function automatic logic [2:0] rf_rdsel(input logic [1:0] n);
    return {1'b1, n};
  endfunction

endpackage

// File: rtl/cu_decoder.sv
// Combinational decode of (state, IR) into the datapath control word.
module cu_decoder
  import cu_pkg::*;
(
  input  state_t      state,
  input  logic [15:0] ir_out,
  input  logic [3:0]  alu_pass,
  output ctrl_t       cw
);

  logic [3:0] op;
  logic [1:0] rd;
  logic [1:0] rs;
  logic       unused_imm;

  assign op = ir_out[15:12];
  assign rd = ir_out[11:10];
  assign rs = ir_out[9:8];
  // The immediate reaches the datapath through the IR LSB mux path, not through this block.
  assign unused_imm = ^ir_out[7:0];

  always_comb begin
    cw = CTRL_IDLE;
    case (state)
      INIT: begin
        cw.regsel_arf = 4'b0001;
        cw.funsel_arf = 2'b00;
        cw.IR_enable  = 1'b1;
        cw.funsel_IR  = 2'b00;
      end
      FETCH_L, FETCH_H: begin
        cw.outbsel    = 2'b11;
        cw.csMEM      = 1'b0;
        cw.wrMEM      = 1'b0;
        cw.IR_enable  = 1'b1;
        cw.funsel_IR  = 2'b01;
        cw.IR_lh      = (state == FETCH_H);
        cw.regsel_arf = 4'b0001;
        cw.funsel_arf = 2'b11;
      end
      EXEC1: begin
        case (op)
          OP_LDI: begin
            cw.MUXSelA   = 2'd2;
            cw.regsel_rf = rf_onehot(rd);
            cw.funsel_rf = 2'b01;
          end
          OP_LD, OP_ST: begin
            cw.MUXSelB    = 2'd2;
            cw.regsel_arf = 4'b1000;
            cw.funsel_arf = 2'b01;
          end
          OP_MOV: begin
            cw.rf_o1sel   = rf_rdsel(rs);
            cw.MUXSelC    = 1'b0;
            cw.funsel_alu = alu_pass;
            cw.MUXSelA    = 2'd0;
            cw.regsel_rf  = rf_onehot(rd);
            cw.funsel_rf  = 2'b01;
          end
          OP_INC: begin
            cw.regsel_rf = rf_onehot(rd);
            cw.funsel_rf = 2'b11;
          end
          OP_DEC: begin
            cw.regsel_rf = rf_onehot(rd);
            cw.funsel_rf = 2'b10;
          end
          OP_CLR: begin
            cw.regsel_rf = rf_onehot(rd);
            cw.funsel_rf = 2'b00;
          end
          OP_BRA: begin
            cw.MUXSelB    = 2'd2;
            cw.regsel_arf = 4'b0001;
            cw.funsel_arf = 2'b01;
          end
          default: ;
        endcase
      end
      EXEC2: begin
        if (op == OP_LD) begin
          cw.outbsel   = 2'b00;
          cw.csMEM     = 1'b0;
          cw.MUXSelA   = 2'd1;
          cw.regsel_rf = rf_onehot(rd);
          cw.funsel_rf = 2'b01;
        end else if (op == OP_ST) begin
          cw.rf_o1sel   = rf_rdsel(rd);
          cw.MUXSelC    = 1'b0;
          cw.funsel_alu = alu_pass;
          cw.outbsel    = 2'b00;
          cw.csMEM      = 1'b0;
          cw.wrMEM      = 1'b1;
        end
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/control_unit.sv
// Hardwired sequencer: two-byte fetch, 1-2 cycle execute, halt until reset.
// Holds the state register and next-state logic; control words come from cu_decoder.
module control_unit
  import cu_pkg::*;
#(
  parameter logic [3:0] ALU_PASS_A = ALU_PASS_A_DEFAULT
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        run,
  input  logic [15:0] ir_out,
  output logic        halted,
  output logic [2:0]  state_o,
  output logic [1:0]  outasel,
  output logic [1:0]  outbsel,
  output logic [1:0]  funsel_IR,
  output logic [1:0]  funsel_arf,
  output logic [1:0]  funsel_rf,
  output logic [3:0]  funsel_alu,
  output logic [3:0]  regsel_rf,
  output logic [3:0]  regsel_arf,
  output logic [3:0]  rf_tsel,
  output logic        wrMEM,
  output logic        csMEM,
  output logic        IR_enable,
  output logic        IR_lh,
  output logic        MUXSelC,
  output logic [1:0]  MUXSelA,
  output logic [1:0]  MUXSelB,
  output logic [2:0]  rf_o1sel,
  output logic [2:0]  rf_o2sel
);

  state_t state;
  state_t state_next;
  ctrl_t  cw_dec;
  ctrl_t  cw;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) state <= INIT;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      INIT:    state_next = IDLE;
      IDLE:    if (run) state_next = FETCH_L;
      FETCH_L: state_next = FETCH_H;
      FETCH_H: state_next = EXEC1;
      EXEC1: begin
        if (ir_out[15:12] == OP_LD || ir_out[15:12] == OP_ST) state_next = EXEC2;
        else if (ir_out[15:12] == OP_HLT)                      state_next = HALT;
        else                                                   state_next = FETCH_L;
      end
      EXEC2:   state_next = FETCH_L;
      HALT:    state_next = HALT;
      default: state_next = INIT;
    endcase
  end

  cu_decoder u_decoder (
    .state    (state),
    .ir_out   (ir_out),
    .alu_pass (ALU_PASS_A),
    .cw       (cw_dec)
  );

  // Mask the word while reset is high so an in-flight write cannot land.
  assign cw = reset ? CTRL_IDLE : cw_dec;

  assign halted     = (state == HALT);
  assign state_o    = state;
  assign outasel    = cw.outasel;
  assign outbsel    = cw.outbsel;
  assign funsel_IR  = cw.funsel_IR;
  assign funsel_arf = cw.funsel_arf;
  assign funsel_rf  = cw.funsel_rf;
  assign funsel_alu = cw.funsel_alu;
  assign regsel_rf  = cw.regsel_rf;
  assign regsel_arf = cw.regsel_arf;
  assign rf_tsel    = cw.rf_tsel;
  assign wrMEM      = cw.wrMEM;
  assign csMEM      = cw.csMEM;
  assign IR_enable  = cw.IR_enable;
  assign IR_lh      = cw.IR_lh;
  assign MUXSelC    = cw.MUXSelC;
  assign MUXSelA    = cw.MUXSelA;
  assign MUXSelB    = cw.MUXSelB;
  assign rf_o1sel   = cw.rf_o1sel;
  assign rf_o2sel   = cw.rf_o2sel;

endmodule

// File: tb/tb_control_unit.sv
// Bench for control_unit: a small behavioural datapath closes the IR loop, and a scoreboard
// checks each retired instruction against hand-computed register/memory/PC results.
module tb_control_unit;
  import cu_pkg::*;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        run = 1'b0;
  logic [15:0] ir_out;
  logic        halted;
  logic [2:0]  state_o;
  logic [1:0]  outasel, outbsel, funsel_IR, funsel_arf, funsel_rf;
  logic [3:0]  funsel_alu, regsel_rf, regsel_arf, rf_tsel;
  logic        wrMEM, csMEM, IR_enable, IR_lh, MUXSelC;
  logic [1:0]  MUXSelA, MUXSelB;
  logic [2:0]  rf_o1sel, rf_o2sel;

  always #5 clock = ~clock;

  control_unit dut (
    .clock(clock), .reset(reset), .run(run), .ir_out(ir_out), .halted(halted),
    .state_o(state_o), .outasel(outasel), .outbsel(outbsel), .funsel_IR(funsel_IR),
    .funsel_arf(funsel_arf), .funsel_rf(funsel_rf), .funsel_alu(funsel_alu),
    .regsel_rf(regsel_rf), .regsel_arf(regsel_arf), .rf_tsel(rf_tsel), .wrMEM(wrMEM),
    .csMEM(csMEM), .IR_enable(IR_enable), .IR_lh(IR_lh), .MUXSelC(MUXSelC),
    .MUXSelA(MUXSelA), .MUXSelB(MUXSelB), .rf_o1sel(rf_o1sel), .rf_o2sel(rf_o2sel)
  );

  localparam logic [40:0] IDLE_CW = 41'd1 << 13;  // only csMEM set
  logic [40:0] cw_now;
  assign cw_now = {outasel, outbsel, funsel_IR, funsel_arf, funsel_rf, funsel_alu, regsel_rf,
                   regsel_arf, rf_tsel, wrMEM, csMEM, IR_enable, IR_lh, MUXSelC, MUXSelA,
                   MUXSelB, rf_o1sel, rf_o2sel};

  // Behavioural datapath (memory, PC, AR, IR, R1..R4); ALU is a pass-through stub.
  logic [7:0]  mem [256];
  logic [7:0]  pc, ar;
  logic [15:0] ir;
  logic [7:0]  rf [4];
  logic [7:0]  addr_bus, mem_rd, alu_out, mux_a;
  logic        poke_en = 1'b0;
  logic [7:0]  poke_addr = 8'h00, poke_data = 8'h00;
  int          wr_count = 0;

  assign ir_out = ir;

  function automatic logic [7:0] reg_next(input logic [7:0] cur, input logic [1:0] fs,
                                          input logic [7:0] ld);
    case (fs)
      2'b00:   return 8'h00;
      2'b01:   return ld;
      2'b10:   return cur - 8'd1;
      default: return cur + 8'd1;
    endcase
  endfunction

  always_comb begin
    addr_bus = (outbsel == 2'b11) ? pc : ar;
    mem_rd   = mem[addr_bus];
    alu_out  = rf[rf_o1sel[1:0]];
    case (MUXSelA)
      2'd0:    mux_a = alu_out;
      2'd1:    mux_a = mem_rd;
      default: mux_a = ir[7:0];
    endcase
  end

  always @(posedge clock) begin
    if (poke_en) mem[poke_addr] <= poke_data;
    if (!csMEM && wrMEM) begin
      mem[addr_bus] <= alu_out;
      wr_count <= wr_count + 1;
    end
    if (IR_enable) begin
      if (funsel_IR == 2'b00) ir <= 16'h0000;
      else if (funsel_IR == 2'b01) begin
        if (IR_lh) ir[15:8] <= mem_rd;
        else       ir[7:0]  <= mem_rd;
      end
    end
    if (regsel_arf[0]) pc <= reg_next(pc, funsel_arf, ir[7:0]);
    if (regsel_arf[3]) ar <= reg_next(ar, funsel_arf, ir[7:0]);
    for (int i = 0; i < 4; i++) begin
      if (regsel_rf[3-i]) rf[i] <= reg_next(rf[i], funsel_rf, mux_a);
    end
  end

  // Scoreboard
  typedef struct {
    string      name;
    logic [7:0] pc;
    int         ridx;
    logic [7:0] rval;
    bit         chk_ar;
    logic [7:0] ar;
    bit         chk_mem;
    logic [7:0] maddr;
    logic [7:0] mval;
    int         cycles;
  } exp_t;

  exp_t sb[$];
  int   tests = 0;
  int   fails = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic void expect_op(input string name, input logic [7:0] epc, input int ridx,
                                    input logic [7:0] rval, input bit chk_ar,
                                    input logic [7:0] ear, input bit chk_mem,
                                    input logic [7:0] maddr, input logic [7:0] mval,
                                    input int cycles);
    exp_t e;
    e.name = name; e.pc = epc; e.ridx = ridx; e.rval = rval; e.chk_ar = chk_ar; e.ar = ear;
    e.chk_mem = chk_mem; e.maddr = maddr; e.mval = mval; e.cycles = cycles;
    sb.push_back(e);
  endfunction

  // An instruction retires on the edge that leaves its last execute cycle.
  logic retire_q;
  int   cyc;
  always @(posedge clock or posedge reset) begin
    if (reset) begin
      retire_q <= 1'b0;
      cyc      <= 0;
    end else begin
      retire_q <= (state_o == EXEC2) ||
                  (state_o == EXEC1 && ir_out[15:12] != OP_LD &&
                   ir_out[15:12] != OP_ST && ir_out[15:12] != OP_HLT);
      cyc      <= (state_o == FETCH_L) ? 1 : cyc + 1;
    end
  end

  always @(negedge clock) begin
    exp_t e;
    if (retire_q) begin
      if (sb.size() == 0) check("unexpected_retire", 1, 0);
      else begin
        e = sb.pop_front();
        check({e.name, "_pc"}, pc, e.pc);
        check({e.name, "_cycles"}, cyc, e.cycles);
        if (e.ridx >= 0) check({e.name, "_reg"}, rf[e.ridx[1:0]], e.rval);
        if (e.chk_ar) check({e.name, "_ar"}, ar, e.ar);
        if (e.chk_mem) check({e.name, "_mem"}, mem[e.maddr], e.mval);
      end
    end
  end

  task automatic poke_word(input logic [7:0] a, input logic [7:0] lo, input logic [7:0] hi);
    poke_en = 1'b1; poke_addr = a; poke_data = lo;
    @(negedge clock);
    poke_addr = a + 8'd1; poke_data = hi;
    @(negedge clock);
    poke_en = 1'b0;
  endtask

  task automatic wait_halt(input int budget);
    int n = 0;
    while (!halted && n < budget) begin
      @(negedge clock);
      n++;
    end
    check("halt_reached", halted, 1'b1);
  endtask

  task automatic wait_sb_empty(input int budget);
    int n = 0;
    while (sb.size() != 0 && n < budget) begin
      @(negedge clock);
      n++;
    end
    check("sb_drained_in_time", sb.size(), 0);
  endtask

  initial begin
    int bad;
    int n;
    #1;
    check("rst_state", state_o, INIT);
    check("rst_halted", halted, 1'b0);
    check("rst_idle_word", cw_now, IDLE_CW);

    // Program A
    poke_word(8'h00, 8'h5A, 8'h00);  // LDI R1,5A
    poke_word(8'h02, 8'h10, 8'h14);  // LD  R2,[10]
    poke_word(8'h04, 8'h20, 8'h20);  // ST  R1,[20]
    poke_word(8'h06, 8'hFF, 8'h00);  // LDI R1,FF
    poke_word(8'h08, 8'h00, 8'h40);  // INC R1
    poke_word(8'h0A, 8'h00, 8'h39);  // MOV R3,R2
    poke_word(8'h0C, 8'h30, 8'h70);  // BRA 30
    poke_word(8'h10, 8'hC3, 8'h00);  // data
    poke_word(8'h30, 8'h00, 8'h58);  // DEC R3
    poke_word(8'h32, 8'h00, 8'h64);  // CLR R2
    poke_word(8'h34, 8'h00, 8'h90);  // NOP (opcode 9)
    poke_word(8'h36, 8'h00, 8'hF0);  // HLT

    reset = 1'b0;
    @(posedge clock); #1;
    check("init_pc_clear", pc, 8'h00);
    check("init_ir_clear", ir, 16'h0000);
    check("init_to_idle", state_o, IDLE);

    expect_op("ldi_r1",  8'h02, 0, 8'h5A, 0, 8'h00, 0, 8'h00, 8'h00, 3);
    expect_op("ld_r2",   8'h04, 1, 8'hC3, 1, 8'h10, 0, 8'h00, 8'h00, 4);
    expect_op("st_r1",   8'h06, 0, 8'h5A, 1, 8'h20, 1, 8'h20, 8'h5A, 4);
    expect_op("ldi_ff",  8'h08, 0, 8'hFF, 0, 8'h00, 0, 8'h00, 8'h00, 3);
    expect_op("inc_wrap", 8'h0A, 0, 8'h00, 0, 8'h00, 0, 8'h00, 8'h00, 3);
    expect_op("mov_r3",  8'h0C, 2, 8'hC3, 0, 8'h00, 0, 8'h00, 8'h00, 3);
    expect_op("bra_30",  8'h30, -1, 8'h00, 0, 8'h00, 0, 8'h00, 8'h00, 3);
    expect_op("dec_r3",  8'h32, 2, 8'hC2, 0, 8'h00, 0, 8'h00, 8'h00, 3);
    expect_op("clr_r2",  8'h34, 1, 8'h00, 0, 8'h00, 0, 8'h00, 8'h00, 3);
    expect_op("nop_9",   8'h36, 0, 8'h00, 0, 8'h00, 0, 8'h00, 8'h00, 3);
    @(negedge clock);
    run = 1'b1;
    wait_halt(200);
    check("halt_pc", pc, 8'h38);
    check("st_single_write", wr_count, 1);
    bad = 0;
    repeat (20) begin
      @(negedge clock);
      if (!halted || state_o !== HALT || cw_now !== IDLE_CW) bad++;
    end
    check("halt_hold_20", bad, 0);

    // Program B: BRA 00 must refetch from address 00
    reset = 1'b1; run = 1'b0;
    poke_word(8'h00, 8'h77, 8'h0C);  // LDI R4,77
    poke_word(8'h02, 8'h00, 8'h70);  // BRA 00
    reset = 1'b0;
    expect_op("ldi_r4",   8'h02, 3, 8'h77, 0, 8'h00, 0, 8'h00, 8'h00, 3);
    expect_op("bra_00",   8'h00, -1, 8'h00, 0, 8'h00, 0, 8'h00, 8'h00, 3);
    expect_op("ldi_r4_2", 8'h02, 3, 8'h77, 0, 8'h00, 0, 8'h00, 8'h00, 3);
    run = 1'b1;
    wait_sb_empty(100);
    reset = 1'b1; run = 1'b0;

    // Program C: reset during EXEC2 of ST R4,[40]
    poke_word(8'h40, 8'hEE, 8'h00);
    poke_word(8'h00, 8'h40, 8'h2C);
    reset = 1'b0; run = 1'b1;
    n = 0;
    while (state_o != EXEC2 && n < 20) begin
      @(negedge clock);
      n++;
    end
    check("st_exec2_reached", state_o, EXEC2);
    reset = 1'b1; run = 1'b0;
    #1;
    check("rst_mid_state", state_o, INIT);
    check("rst_mid_wrmem", wrMEM, 1'b0);
    check("rst_mid_csmem", csMEM, 1'b1);
    @(negedge clock);
    reset = 1'b0;
    @(posedge clock); #1;
    check("rst_mid_pc", pc, 8'h00);
    check("rst_mid_ir", ir, 16'h0000);
    check("rst_mid_mem", mem[8'h40], 8'hEE);
    check("rst_mid_wrcount", wr_count, 1);
    check("sb_final_empty", sb.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
